// File: rtl/gcd_engine.sv
// gcd_engine: binary (Stein) GCD of two unsigned WIDTH-bit operands.
// Common factors of two are stripped first and counted in k. The odd
// remainders are then reduced by halving and halved differences until
// they are equal, and the stripped factors are restored with one shift.
// res and done come from registers. ready depends only on the FSM state.
module gcd_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] u,
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] res,
    output logic             done,
    output logic             ready
);

    // k counts common factors of two. At most WIDTH-1 of them can be
    // stripped from non-zero operands, so this width leaves headroom.
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        STRIP,
        REDUCE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] u_reg, u_next;
    logic [WIDTH-1:0] v_reg, v_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             done_reg, done_next;
    logic             accept;

    // A load is taken only while the engine is parked (idle or holding a result).
    assign ready  = (state_reg == IDLE) || (state_reg == DONE);
    assign accept = ld && ready;

    assign res  = res_reg;
    assign done = done_reg;

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            u_reg     <= '0;
            v_reg     <= '0;
            k_reg     <= '0;
            res_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            u_reg     <= u_next;
            v_reg     <= v_next;
            k_reg     <= k_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath updates; every register holds unless a rule below changes it.
    always_comb begin
        state_next = state_reg;
        u_next     = u_reg;
        v_next     = v_reg;
        k_next     = k_reg;
        res_next   = res_reg;
        done_next  = done_reg;

        if (accept) begin
            // The accepting edge drops done and starts the new operation.
            u_next    = u;
            v_next    = v;
            k_next    = '0;
            done_next = 1'b0;
            if ((u == '0) || (v == '0)) begin
                // gcd(0,x) = x. The result is posted at once.
                // done follows one edge later from the DONE state.
                res_next   = u | v;
                state_next = DONE;
            end else begin
                state_next = STRIP;
            end
        end else begin
            case (state_reg)
                STRIP: begin
                    if (!u_reg[0] && !v_reg[0]) begin
                        u_next = u_reg >> 1;
                        v_next = v_reg >> 1;
                        k_next = k_reg + KW'(1);
                    end else begin
                        state_next = REDUCE;
                    end
                end
                REDUCE: begin
                    // At least one value is odd here. Neither value ever reaches zero.
                    if (u_reg == v_reg) begin
                        state_next = SHIFT;
                    end else if (!u_reg[0]) begin
                        u_next = u_reg >> 1;
                    end else if (!v_reg[0]) begin
                        v_next = v_reg >> 1;
                    end else if (u_reg > v_reg) begin
                        // Both values are odd, so the difference is even and can be halved.
                        u_next = (u_reg - v_reg) >> 1;
                    end else begin
                        v_next = (v_reg - u_reg) >> 1;
                    end
                end
                SHIFT: begin
                    res_next   = u_reg << k_reg;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
                DONE: begin
                    done_next = 1'b1;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized and directed check of gcd_engine (WIDTH=16).
// The reference GCD is plain repeated subtraction. A per-cycle monitor
// compares res against the result expected for the last accepted load.
module tb_gcd_engine;

    localparam int W      = 16;
    localparam int LAT_MAX = 3 * W + 3;

    logic         clk;
    logic         reset;
    logic         ld;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [W-1:0] res;
    logic         done;
    logic         ready;

    int           checks;
    int           passes;
    logic [W-1:0] exp_res;
    bit           have_op;

    gcd_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .u     (u),
        .v     (v),
        .res   (res),
        .done  (done),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GCD by repeated subtraction. gcd(0,x) is x.
    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == '0) return b;
        if (b == '0) return a;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_le(input string name, input longint act, input longint lim);
        checks++;
        if (act <= lim) passes++;
        else $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
    endtask

    // Per-cycle monitor. Once a load is accepted, a raised done must carry the reference result and ready.
    // With no load accepted since reset, done must stay low.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (have_op) begin
                    chk("mon_res", res, exp_res);
                    chk("mon_ready", ready, 1);
                end else begin
                    chk("mon_spurious_done", done, 0);
                end
            end
        end
    end

    // Called on a negedge. Waits for ready, issues ld for one edge, then scrambles u/v while busy.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_wait", ready, 1);
        u  = a;
        v  = b;
        ld = 1'b1;
        @(posedge clk);
        have_op = 1'b1;
        exp_res = gcd_ref(a, b);
        #1;
        ld = 1'b0;
        u  = W'($urandom);
        v  = W'($urandom);
        @(negedge clk);
        chk("done_drop", done, 0);
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < LAT_MAX + 4) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output int lat);
        start_op(a, b);
        wait_done(lat);
        r = res;
        $display("op gcd(%0d,%0d) res=%0d latency=%0d", a, b, r, lat);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        int           sel;
        int           worst;

        checks  = 0;
        passes  = 0;
        have_op = 1'b0;
        exp_res = '0;
        reset   = 1'b1;
        ld      = 1'b0;
        u       = '0;
        v       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_res", res, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Directed latency and result examples
        run_op(16'd12, 16'd18, r, lat);
        chk("g12_18_res", r, 6);
        chk("g12_18_lat", lat, 6);
        chk("g12_18_ready", ready, 1);
        run_op(16'd0, 16'd45, r, lat);
        chk("g0_45_res", r, 45);
        chk("g0_45_lat", lat, 1);
        run_op(16'd45, 16'd0, r, lat);
        chk("g45_0_lat", lat, 1);
        run_op(16'd0, 16'd0, r, lat);
        chk("g0_0_res", r, 0);
        run_op(16'd255, 16'd255, r, lat);
        chk("g255_255_res", r, 255);
        chk("g255_255_lat", lat, 3);
        run_op(16'd65535, 16'd65535, r, lat);
        chk("gffff_ffff_lat", lat, 3);
        run_op(16'd65535, 16'd1, r, lat);
        chk("gffff_1_res", r, 1);
        chk_le("gffff_1_lat", lat, LAT_MAX);
        run_op(16'd32768, 16'd16384, r, lat);
        chk("gpow2_res", r, 16384);

        // A load while busy is ignored
        start_op(16'd24, 16'd36);
        @(posedge clk);
        #1;
        ld = 1'b1;
        u  = 16'd5;
        v  = 16'd7;
        @(posedge clk);
        #1;
        ld = 1'b0;
        @(negedge clk);
        wait_done(lat);
        chk("busy_ld_res", res, 12);
        $display("op gcd(24,36) with ignored ld res=%0d latency=%0d", res, lat + 0);

        // Reset mid-operation aborts it; a load coincident with reset is ignored
        start_op(16'd200, 16'd150);
        repeat (3) @(posedge clk);
        #2;
        reset   = 1'b1;
        have_op = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_res", res, 0);
        chk("abort_ready", ready, 1);
        ld = 1'b1;
        u  = 16'd0;
        v  = 16'd7;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ld    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
        end
        $display("op reset abort of gcd(200,150) done=%0d res=%0d", done, res);
        run_op(16'd9, 16'd6, r, lat);
        chk("after_rst_res", r, 3);

        // Randomized back-to-back operations
        worst = 0;
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            a   = W'($urandom);
            b   = W'($urandom);
            case (sel)
                0: a = '0;
                1: b = '0;
                2: b = a;
                3: begin
                    a = W'($urandom_range(1, 255)) << $urandom_range(0, 8);
                    b = W'($urandom_range(1, 255)) << $urandom_range(0, 8);
                end
                4: b = W'($urandom_range(1, 3));
                default: ;
            endcase
            run_op(a, b, r, lat);
            chk("rand_res", r, gcd_ref(a, b));
            chk_le("rand_lat", lat, LAT_MAX);
            if (lat > worst) worst = lat;
        end
        $display("random phase worst latency=%0d", worst);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
